// File: rtl/jtframe_sdram_pkg.sv
// jtframe_sdram_pkg: shared FSM state encoding, SDRAM address/data/read widths and index-width helper
package jtframe_sdram_pkg;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int RW = 32;
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY, GAP} state_t;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/jtframe_sdram_arb_if.sv
// jtframe_sdram_arb_if: slot request bus plus controller handshake; master = arbiter side (slot_*, sdram_ack/rdy/dout in; slot_ok, data_read, sdram_req/rnw/addr/din, busy, err out), slave = slots/controller side
interface jtframe_sdram_arb_if
    import jtframe_sdram_pkg::*;
#(
    parameter int SLOTS = 4
);
    logic [SLOTS-1:0]    slot_req;
    logic [SLOTS-1:0]    slot_rnw;
    logic [AW*SLOTS-1:0] slot_addr;
    logic [DW*SLOTS-1:0] slot_wrdata;
    logic [SLOTS-1:0]    slot_ok;
    logic [RW-1:0]       data_read;
    logic                sdram_req;
    logic                sdram_rnw;
    logic [AW-1:0]       sdram_addr;
    logic [DW-1:0]       sdram_din;
    logic                sdram_ack;
    logic                sdram_rdy;
    logic [RW-1:0]       sdram_dout;
    logic                busy;
    logic                err;
    modport master (
        input  slot_req, slot_rnw, slot_addr, slot_wrdata, sdram_ack, sdram_rdy, sdram_dout,
        output slot_ok, data_read, sdram_req, sdram_rnw, sdram_addr, sdram_din, busy, err
    );
    modport slave (
        output slot_req, slot_rnw, slot_addr, slot_wrdata, sdram_ack, sdram_rdy, sdram_dout,
        input  slot_ok, data_read, sdram_req, sdram_rnw, sdram_addr, sdram_din, busy, err
    );
endinterface

// File: rtl/jtframe_prio_enc.sv
// jtframe_prio_enc: lowest-index-wins priority encoder; req in, idx of first set bit and valid (any set) out
module jtframe_prio_enc
    import jtframe_sdram_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = IW'(i);
    end
    assign valid = |req;
endmodule

// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb: fixed-priority SDRAM slot arbiter with watchdog; clk, rst (sync, active-high), bus (jtframe_sdram_arb_if.master)
module jtframe_sdram_arb
    import jtframe_sdram_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int TOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    jtframe_sdram_arb_if.master bus
);
    localparam int IW = idx_w(SLOTS);
    state_t          st, st_nx;
    logic [IW-1:0]   grant, grant_nx, idx;
    logic            valid, done, abort;
    logic [15:0]     cnt, cnt_nx;
    logic            req_nx, rnw_nx, busy_nx, err_nx;
    logic [AW-1:0]   addr_nx;
    logic [DW-1:0]   din_nx;
    logic [SLOTS-1:0] ok_nx;
    logic [RW-1:0]   dr_nx;
    jtframe_prio_enc #(.N(SLOTS), .IW(IW)) u_enc (
        .req   (bus.slot_req),
        .idx   (idx),
        .valid (valid)
    );
    always_comb begin
        st_nx    = st;
        grant_nx = grant;
        cnt_nx   = cnt;
        req_nx   = bus.sdram_req;
        rnw_nx   = bus.sdram_rnw;
        addr_nx  = bus.sdram_addr;
        din_nx   = bus.sdram_din;
        ok_nx    = '0;
        dr_nx    = bus.data_read;
        busy_nx  = bus.busy;
        err_nx   = bus.err;
        done     = 1'b0;
        abort    = 1'b0;
        case (st)
            IDLE: if (valid) begin
                st_nx    = WAIT_ACK;
                grant_nx = idx;
                cnt_nx   = '0;
                req_nx   = 1'b1;
                busy_nx  = 1'b1;
                rnw_nx   = bus.slot_rnw[idx];
                addr_nx  = bus.slot_addr[int'(idx)*AW +: AW];
                din_nx   = bus.slot_wrdata[int'(idx)*DW +: DW];
            end
            WAIT_ACK: begin
                cnt_nx = cnt + 16'd1;
                done   = bus.sdram_ack && bus.sdram_rdy;
                abort  = !bus.sdram_ack && cnt >= 16'(TOUT - 1);
                if (bus.sdram_ack && !bus.sdram_rdy) begin
                    req_nx = 1'b0;
                    st_nx  = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                cnt_nx = cnt + 16'd1;
                done   = bus.sdram_rdy;
                abort  = !bus.sdram_rdy && cnt >= 16'(TOUT - 1);
            end
            default: st_nx = IDLE;
        endcase
        if (done) begin
            ok_nx   = SLOTS'(1) << grant;
            dr_nx   = bus.sdram_rnw ? bus.sdram_dout : bus.data_read;
            req_nx  = 1'b0;
            busy_nx = 1'b0;
            st_nx   = GAP;
        end
        if (abort) begin
            req_nx  = 1'b0;
            busy_nx = 1'b0;
            err_nx  = 1'b1;
            st_nx   = GAP;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= IDLE;
            grant          <= '0;
            cnt            <= '0;
            bus.sdram_req  <= 1'b0;
            bus.sdram_rnw  <= 1'b1;
            bus.sdram_addr <= '0;
            bus.sdram_din  <= '0;
            bus.slot_ok    <= '0;
            bus.data_read  <= '0;
            bus.busy       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            st             <= st_nx;
            grant          <= grant_nx;
            cnt            <= cnt_nx;
            bus.sdram_req  <= req_nx;
            bus.sdram_rnw  <= rnw_nx;
            bus.sdram_addr <= addr_nx;
            bus.sdram_din  <= din_nx;
            bus.slot_ok    <= ok_nx;
            bus.data_read  <= dr_nx;
            bus.busy       <= busy_nx;
            bus.err        <= err_nx;
        end
    end
endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// tb_jtframe_sdram_arb: directed scoreboard bench for jtframe_sdram_arb
module tb_jtframe_sdram_arb;
    typedef struct {
        logic [3:0]  ok;
        logic [31:0] d;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   n_ok = 0;
    int   cyc_n = 0;
    exp_t sb[$];
    jtframe_sdram_arb_if #(.SLOTS(4)) bus ();
    jtframe_sdram_arb #(.SLOTS(4), .TOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) begin
        if (bus.slot_ok !== 4'b0) begin
            if (sb.size() == 0) chk("unexpected_ok", 64'(bus.slot_ok), 64'h0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("ok_slot", 64'(bus.slot_ok), 64'(e.ok));
                chk("ok_data", 64'(bus.data_read), 64'(e.d));
                n_ok++;
            end
        end
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic set_slot(input int i, input logic rnw, input logic [21:0] a, input logic [15:0] d);
        bus.slot_rnw[i] = rnw;
        bus.slot_addr[i*22 +: 22] = a;
        bus.slot_wrdata[i*16 +: 16] = d;
        bus.slot_req[i] = 1'b1;
    endtask
    task automatic wait_req(input string tag);
        int k = 0;
        while (bus.sdram_req !== 1'b1 && k < 20) begin
            cyc(1);
            k++;
        end
        chk(tag, 64'(bus.sdram_req), 64'h1);
    endtask
    task automatic serve(input string tag, input logic [21:0] ea, input logic er, input logic [15:0] ed,
                         input logic [31:0] dout, input int ack_dly, input int rdy_dly, input logic same);
        wait_req({tag, "_grant"});
        chk({tag, "_addr"}, 64'(bus.sdram_addr), 64'(ea));
        chk({tag, "_rnw"}, 64'(bus.sdram_rnw), 64'(er));
        chk({tag, "_busy"}, 64'(bus.busy), 64'h1);
        if (!er) chk({tag, "_din"}, 64'(bus.sdram_din), 64'(ed));
        cyc(ack_dly);
        bus.sdram_ack = 1'b1;
        bus.sdram_rdy = same;
        bus.sdram_dout = dout;
        cyc(1);
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
        if (!same) begin
            chk({tag, "_req_drop"}, 64'(bus.sdram_req), 64'h0);
            cyc(rdy_dly);
            bus.sdram_rdy = 1'b1;
            bus.sdram_dout = dout;
            cyc(1);
            bus.sdram_rdy = 1'b0;
        end
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, 64'(bus.sdram_req), 64'h0);
        chk({tag, "_rnw"}, 64'(bus.sdram_rnw), 64'h1);
        chk({tag, "_addr"}, 64'(bus.sdram_addr), 64'h0);
        chk({tag, "_din"}, 64'(bus.sdram_din), 64'h0);
        chk({tag, "_ok"}, 64'(bus.slot_ok), 64'h0);
        chk({tag, "_data"}, 64'(bus.data_read), 64'h0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'h0);
        chk({tag, "_err"}, 64'(bus.err), 64'h0);
    endtask
    initial begin
        int t1, t3, hi, snap;
        bus.slot_req = '0;
        bus.slot_rnw = '0;
        bus.slot_addr = '0;
        bus.slot_wrdata = '0;
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
        bus.sdram_dout = '0;
        cyc(3);
        chk_reset("reset");
        rst = 1'b0;
        cyc(1);
        set_slot(2, 1'b1, 22'h12345, 16'h0);
        sb.push_back('{4'b0100, 32'hDEADBEEF});
        serve("read", 22'h12345, 1'b1, 16'h0, 32'hDEADBEEF, 1, 2, 1'b0);
        bus.slot_req[2] = 1'b0;
        chk("read_busy_end", 64'(bus.busy), 64'h0);
        cyc(1);
        chk("read_ok_one_cycle", 64'(bus.slot_ok), 64'h0);
        chk("read_data_hold", 64'(bus.data_read), 64'hDEADBEEF);
        cyc(2);
        set_slot(1, 1'b1, 22'h00111, 16'h0);
        set_slot(3, 1'b1, 22'h00333, 16'h0);
        sb.push_back('{4'b0010, 32'h11111111});
        sb.push_back('{4'b1000, 32'h33333333});
        serve("prio1", 22'h00111, 1'b1, 16'h0, 32'h11111111, 0, 0, 1'b0);
        bus.slot_req[1] = 1'b0;
        t1 = cyc_n;
        serve("prio3", 22'h00333, 1'b1, 16'h0, 32'h33333333, 0, 0, 1'b0);
        bus.slot_req[3] = 1'b0;
        t3 = cyc_n;
        chk("prio_spacing", 64'((t3 - t1) >= 4), 64'h1);
        cyc(2);
        set_slot(0, 1'b0, 22'h3FFFFF, 16'hA5A5);
        sb.push_back('{4'b0001, 32'h33333333});
        serve("write", 22'h3FFFFF, 1'b0, 16'hA5A5, 32'hBADBAD00, 1, 1, 1'b0);
        bus.slot_req[0] = 1'b0;
        cyc(1);
        chk("write_data_keep", 64'(bus.data_read), 64'h33333333);
        cyc(1);
        set_slot(2, 1'b1, 22'h2AAAA, 16'h0);
        sb.push_back('{4'b0100, 32'hCAFEF00D});
        serve("same", 22'h2AAAA, 1'b1, 16'h0, 32'hCAFEF00D, 0, 0, 1'b1);
        bus.slot_req[2] = 1'b0;
        chk("same_busy", 64'(bus.busy), 64'h0);
        cyc(1);
        chk("same_ok_one_cycle", 64'(bus.slot_ok), 64'h0);
        cyc(2);
        snap = n_ok;
        set_slot(3, 1'b1, 22'h00ABC, 16'h0);
        sb.push_back('{4'b1000, 32'h0BADF00D});
        wait_req("wd_grant");
        hi = 0;
        while (bus.sdram_req === 1'b1 && hi < 20) begin
            hi++;
            cyc(1);
        end
        chk("wd_req_cycles", 64'(hi), 64'd8);
        chk("wd_err", 64'(bus.err), 64'h1);
        chk("wd_busy", 64'(bus.busy), 64'h0);
        chk("wd_no_ok", 64'(n_ok), 64'(snap));
        serve("wd_retry", 22'h00ABC, 1'b1, 16'h0, 32'h0BADF00D, 1, 1, 1'b0);
        bus.slot_req[3] = 1'b0;
        cyc(1);
        chk("wd_err_sticky", 64'(bus.err), 64'h1);
        chk("wd_retry_done", 64'(n_ok), 64'(snap + 1));
        cyc(1);
        snap = n_ok;
        set_slot(0, 1'b1, 22'h00055, 16'h0);
        wait_req("rst_grant");
        bus.sdram_ack = 1'b1;
        cyc(1);
        bus.sdram_ack = 1'b0;
        cyc(1);
        rst = 1'b1;
        bus.slot_req = '0;
        cyc(1);
        rst = 1'b0;
        bus.sdram_rdy = 1'b1;
        bus.sdram_dout = 32'hFFFFFFFF;
        cyc(1);
        bus.sdram_rdy = 1'b0;
        chk_reset("rst_mid");
        cyc(2);
        chk("rst_no_ok", 64'(n_ok), 64'(snap));
        chk("rst_idle_req", 64'(bus.sdram_req), 64'h0);
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
